rsa_operand_fifo: RTL

Parametrised, first-word-fall-through buffer for RSA operand triples (modulus n, private key d, ciphertext c) between the host load path and the modular-exponentiation core. It replaces fixed 32-bit, 32-entry load/unload storage driven by enIn/enOut. The new block has valid/ready handshakes on both sides, simultaneous push and pop, occupancy reporting, sticky error flags and a synchronous flush.

---
 rtl/rsa_pkg.sv | 21 ++
 rtl/rsa_operand_fifo_if.sv | 50 +++++
 rtl/rsa_fifo_ctrl.sv | 72 +++++++
 rtl/rsa_operand_fifo.sv | 78 +++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and helpers for the RSA operand path: triple struct,
// default operand width and the even-parity function used by the operand FIFO.
package rsa_pkg;

  localparam int RSA_DEFAULT_WIDTH = 32;

  // Parity input is zero-extended to this width so one function serves any WIDTH.
  localparam int RSA_MAX_WIDTH    = 1024;
  localparam int RSA_PARITY_VEC_W = 3 * RSA_MAX_WIDTH;

  typedef struct packed {
    logic [RSA_DEFAULT_WIDTH-1:0] n;
    logic [RSA_DEFAULT_WIDTH-1:0] d;
    logic [RSA_DEFAULT_WIDTH-1:0] c;
  } rsa_triple_t;

  function automatic logic rsa_triple_parity(input logic [RSA_PARITY_VEC_W-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/rsa_operand_fifo_if.sv
// Handshake and status bundle of the RSA operand FIFO.
// RSA_OPERAND_PARITY_EN adds the parity_err / parity_err_seen signals.
interface rsa_operand_fifo_if #(
  parameter int WIDTH = rsa_pkg::RSA_DEFAULT_WIDTH,
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] n_in;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] n_out;
  logic [WIDTH-1:0] d_out;
  logic [WIDTH-1:0] c_out;
  logic [CW-1:0]    level;
  logic [CW-1:0]    count_in;
  logic [CW-1:0]    count_out;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;
`ifdef RSA_OPERAND_PARITY_EN
  logic             parity_err;
  logic             parity_err_seen;
`endif

  modport slave (
    input  clear, in_valid, n_in, d_in, c_in, out_ready,
    output in_ready, out_valid, n_out, d_out, c_out,
    output level, count_in, count_out, full, empty, overflow, underflow
`ifdef RSA_OPERAND_PARITY_EN
    , output parity_err, parity_err_seen
`endif
  );

  modport master (
    output clear, in_valid, n_in, d_in, c_in, out_ready,
    input  in_ready, out_valid, n_out, d_out, c_out,
    input  level, count_in, count_out, full, empty, overflow, underflow
`ifdef RSA_OPERAND_PARITY_EN
    , input parity_err, parity_err_seen
`endif
  );

endinterface

// File: rtl/rsa_fifo_ctrl.sv
// Pointer, occupancy, counter and sticky-flag control for the RSA operand FIFO.
// Full/empty come from the level register only, never from pointer comparison.
module rsa_fifo_ctrl #(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     inValid,
  input  logic                     outReady,
  output logic                     push,
  output logic [$clog2(DEPTH)-1:0] wrPtr,
  output logic [$clog2(DEPTH)-1:0] rdPtr,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   countIn,
  output logic [$clog2(DEPTH):0]   countOut,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     inReady,
  output logic                     outValid
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic pop;

  assign full     = (level == CW'(DEPTH));
  assign empty    = (level == '0);
  assign inReady  = !full;
  assign outValid = !empty;
  assign push     = inValid && inReady;
  assign pop      = outReady && outValid;

  // Clear wins over any handshake in the same cycle; pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      level     <= '0;
      countIn   <= '0;
      countOut  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      level     <= '0;
      countIn   <= '0;
      countOut  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) begin
        wrPtr   <= wrPtr + 1'b1;
        countIn <= countIn + 1'b1;
      end
      if (pop) begin
        rdPtr    <= rdPtr + 1'b1;
        countOut <= countOut + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (inValid && !inReady) overflow <= 1'b1;
      if (outReady && !outValid) underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/rsa_operand_fifo.sv
// First-word-fall-through buffer of RSA {n, d, c} triples with occupancy and sticky flags.
// Define RSA_OPERAND_PARITY_EN to store a per-entry even-parity bit and report head corruption.
module rsa_operand_fifo
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_DEFAULT_WIDTH,
  parameter int DEPTH = 32
) (
  input logic              clk,
  input logic              rst,
  rsa_operand_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  logic             push;
  logic             wrEn;
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [3*WIDTH-1:0] mem [DEPTH];
  logic [3*WIDTH-1:0] headWord;

  rsa_fifo_ctrl #(.DEPTH(DEPTH)) ctrl (
    .clk      (clk),
    .rst      (rst),
    .clear    (bus.clear),
    .inValid  (bus.in_valid),
    .outReady (bus.out_ready),
    .push     (push),
    .wrPtr    (wrPtr),
    .rdPtr    (rdPtr),
    .level    (bus.level),
    .countIn  (bus.count_in),
    .countOut (bus.count_out),
    .full     (bus.full),
    .empty    (bus.empty),
    .overflow (bus.overflow),
    .underflow(bus.underflow),
    .inReady  (bus.in_ready),
    .outValid (bus.out_valid)
  );

  // A flush cancels the write as well as the pointer update.
  assign wrEn = push && !bus.clear;

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr] <= {bus.n_in, bus.d_in, bus.c_in};
  end

  assign headWord  = bus.empty ? '0 : mem[rdPtr];
  assign bus.n_out = headWord[3*WIDTH-1 -: WIDTH];
  assign bus.d_out = headWord[2*WIDTH-1 -: WIDTH];
  assign bus.c_out = headWord[WIDTH-1:0];

`ifdef RSA_OPERAND_PARITY_EN
  logic [DEPTH-1:0] parityMem;
  logic             storedParity;

  always_ff @(posedge clk) begin
    if (wrEn) parityMem[wrPtr] <= rsa_triple_parity(RSA_PARITY_VEC_W'({bus.n_in, bus.d_in, bus.c_in}));
  end

  assign storedParity   = parityMem[rdPtr];
  assign bus.parity_err = bus.out_valid &&
                          (rsa_triple_parity(RSA_PARITY_VEC_W'(headWord)) != storedParity);

  // Remembers that a corrupted triple was actually handed to the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.parity_err_seen <= 1'b0;
    end else if (bus.clear) begin
      bus.parity_err_seen <= 1'b0;
    end else if (bus.out_valid && bus.out_ready && bus.parity_err) begin
      bus.parity_err_seen <= 1'b1;
    end
  end
`endif

endmodule
